// File: rtl/sha_msg_fetch.sv
// Job engine for the SHA accelerator: reads the job registers, streams the message from SRAM over OBI
// in 16-word blocks to the SHA-256 core, and posts completion status back to the register window.
module sha_msg_fetch #(
  parameter logic [31:0] REG_BASE  = 32'h2000_0000,
  parameter int          BLK_WORDS = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  output logic [31:0]               acc_addr_o,
  output logic                      acc_start_mem_addr_o,
  input  logic [31:0]               acc_rdata_i,
  input  logic                      acc_gnt_i,
  output logic                      wdata_acc_o,
  output logic                      obi_req_o,
  output logic [31:0]               obi_addr_o,
  input  logic                      obi_gnt_i,
  input  logic                      obi_rvalid_i,
  input  logic [31:0]               obi_rdata_i,
  input  logic                      obi_err_i,
  output logic [BLK_WORDS*32-1:0]   block_o,
  output logic                      block_valid_o,
  output logic                      block_last_o,
  input  logic                      block_ready_i,
  input  logic                      digest_valid_i,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int                IDX_W    = $clog2(BLK_WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BLK_WORDS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_SRC, S_RD_LEN, S_CLR, S_FETCH,
    S_WAIT_R, S_HAND, S_WAIT_CORE, S_ABORT, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      src_q;
  logic [31:0]      len_q;
  logic [IDX_W-1:0] widx_q;
  logic             last_q;
  logic             err_q;
  logic [31:0]      words_q [BLK_WORDS];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (acc_gnt_i) state_d = S_RD_SRC;
      S_RD_SRC:    state_d = S_RD_LEN;
      S_RD_LEN:    state_d = S_CLR;
      S_CLR: begin
        if (len_q == '0 || len_q[IDX_W-1:0] != '0) state_d = S_DONE;
        else                                       state_d = S_FETCH;
      end
      S_FETCH:     if (obi_gnt_i) state_d = S_WAIT_R;
      S_WAIT_R: begin
        if (obi_rvalid_i) begin
          if (obi_err_i)              state_d = S_ABORT;
          else if (widx_q == LAST_IDX) state_d = S_HAND;
          else                        state_d = S_FETCH;
        end
      end
      S_HAND:      if (block_ready_i) state_d = last_q ? S_WAIT_CORE : S_FETCH;
      S_WAIT_CORE: if (digest_valid_i) state_d = S_DONE;
      // ABORT is only entered on the response itself, and only one request is ever outstanding,
      // so nothing is left pending by the time we get here.
      S_ABORT:     state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      len_q   <= '0;
      widx_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_RD_SRC: src_q <= acc_rdata_i & ~32'h3;
        S_RD_LEN: len_q <= acc_rdata_i;
        S_CLR: begin
          err_q  <= (len_q[IDX_W-1:0] != '0);
          widx_q <= '0;
          last_q <= 1'b0;
        end
        S_WAIT_R: begin
          if (obi_rvalid_i) begin
            if (obi_err_i) begin
              err_q <= 1'b1;
            end else begin
              src_q  <= src_q + 32'd4;
              len_q  <= len_q - 32'd1;
              widx_q <= widx_q + 1'b1;
              if (widx_q == LAST_IDX) last_q <= (len_q == 32'd1);
            end
          end
        end
        S_HAND: if (block_ready_i) widx_q <= '0;
        default: ;
      endcase
    end
  end

  // Message words are pure data: no reset, overwritten slot by slot each block.
  always_ff @(posedge clk_i) begin
    if (state_q == S_WAIT_R && obi_rvalid_i && !obi_err_i) words_q[widx_q] <= obi_rdata_i;
  end

  always_comb begin
    acc_addr_o = REG_BASE;
    case (state_q)
      S_RD_LEN:       acc_addr_o = REG_BASE + 32'h4;
      S_CLR, S_DONE:  acc_addr_o = REG_BASE + 32'hC;
      default:        acc_addr_o = REG_BASE;
    endcase
  end

  always_comb begin
    block_o = '0;
    if (state_q == S_HAND) begin
      for (int i = 0; i < BLK_WORDS; i++) block_o[(BLK_WORDS-1-i)*32 +: 32] = words_q[i];
    end
  end

  assign acc_start_mem_addr_o = (state_q == S_CLR);
  assign wdata_acc_o          = (state_q == S_DONE);
  assign obi_req_o            = (state_q == S_FETCH);
  assign obi_addr_o           = src_q;
  assign block_valid_o        = (state_q == S_HAND);
  assign block_last_o         = (state_q == S_HAND) && last_q;
  assign busy_o               = (state_q != S_IDLE);
  assign err_o                = err_q;

endmodule

// File: tb/tb_sha_msg_fetch.sv
// Directed bench for sha_msg_fetch: register window, SRAM and SHA core are modelled around the DUT.
module tb_sha_msg_fetch;
  localparam logic [31:0] RB = 32'h2000_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  acc_addr;
  logic         acc_start;
  logic [31:0]  acc_rdata;
  logic         acc_gnt;
  logic         wdata_acc;
  logic         obi_req;
  logic [31:0]  obi_addr;
  logic         obi_gnt;
  logic         obi_rvalid = 1'b0;
  logic [31:0]  obi_rdata = '0;
  logic         obi_err = 1'b0;
  logic [511:0] block;
  logic         block_valid;
  logic         block_last;
  logic         block_ready = 1'b0;
  logic         digest_valid = 1'b0;
  logic         busy;
  logic         err;

  always #5 clk = ~clk;

  sha_msg_fetch dut (
    .clk_i(clk), .rst_ni(rst_n),
    .acc_addr_o(acc_addr), .acc_start_mem_addr_o(acc_start), .acc_rdata_i(acc_rdata),
    .acc_gnt_i(acc_gnt), .wdata_acc_o(wdata_acc),
    .obi_req_o(obi_req), .obi_addr_o(obi_addr), .obi_gnt_i(obi_gnt), .obi_rvalid_i(obi_rvalid),
    .obi_rdata_i(obi_rdata), .obi_err_i(obi_err),
    .block_o(block), .block_valid_o(block_valid), .block_last_o(block_last),
    .block_ready_i(block_ready), .digest_valid_i(digest_valid),
    .busy_o(busy), .err_o(err)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // Software/register-window model
  logic [31:0] regs [4] = '{default: 32'h0};
  logic [31:0] sw_src = '0, sw_len = '0;
  logic        go_tog = 1'b0, go_seen = 1'b0;
  always_comb acc_rdata = regs[acc_addr[3:2]];
  assign acc_gnt = regs[2][0];

  always @(posedge clk) begin
    if (go_tog != go_seen) begin
      go_seen <= go_tog;
      regs[0] <= sw_src; regs[1] <= sw_len; regs[2] <= 32'h1;
    end else if (acc_start) begin
      regs[0] <= '0; regs[1] <= '0; regs[2] <= '0;
    end
    if (acc_addr == RB + 32'hC && !acc_gnt) regs[3] <= {31'b0, wdata_acc};
  end

  // SRAM, SHA core and monitors
  assign obi_gnt = obi_req;
  int cyc = 0, gnt_cnt = 0, rsp_cnt = 0, err_at = -1, viol = 0, done_cnt = 0;
  int err_cyc = 0, done_cyc = 0, hold = 0, rdy_delay = 0, dcnt = 0;
  logic [31:0]  addr_q[$];
  logic [511:0] blk_q[$];
  logic         last_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    obi_rvalid <= 1'b0;
    obi_err <= 1'b0;
    if (obi_req && obi_gnt) begin
      obi_rvalid <= 1'b1;
      obi_rdata <= mem(obi_addr);
      obi_err <= (gnt_cnt == err_at);
      gnt_cnt <= gnt_cnt + 1;
      addr_q.push_back(obi_addr);
    end
    if (obi_rvalid) rsp_cnt <= rsp_cnt + 1;
    if (obi_rvalid && obi_err) err_cyc <= cyc;
    if (block_valid && obi_req) viol <= viol + 1;
    if (acc_addr == RB + 32'hC && wdata_acc) begin
      done_cnt <= done_cnt + 1; done_cyc <= cyc;
    end
    if (block_valid && block_ready) begin
      blk_q.push_back(block); last_q.push_back(block_last);
      block_ready <= 1'b0; hold <= 0;
    end else if (block_valid) begin
      if (hold >= rdy_delay) block_ready <= 1'b1;
      else hold <= hold + 1;
    end
    if (block_valid && block_ready && block_last) dcnt <= 3;
    else if (dcnt != 0) dcnt <= dcnt - 1;
    digest_valid <= (dcnt == 1);
  end

  int tests = 0, fails = 0;

  task automatic start_job(input logic [31:0] src, input logic [31:0] len);
    @(negedge clk);
    sw_src = src; sw_len = len; go_tog = ~go_tog;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    tests++; fails++; $display("FAIL %s_timeout busy still %0b after 3000 cycles, want 0", name, busy);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (acc_addr !== RB) begin fails++; $display("FAIL rst_acc_addr got %h want %h", acc_addr, RB); end
    tests++; if (acc_start !== 1'b0) begin fails++; $display("FAIL rst_start got %b want 0", acc_start); end
    tests++; if (wdata_acc !== 1'b0) begin fails++; $display("FAIL rst_wdata got %b want 0", wdata_acc); end
    tests++; if (obi_req !== 1'b0) begin fails++; $display("FAIL rst_req got %b want 0", obi_req); end
    tests++; if (obi_addr !== 32'h0) begin fails++; $display("FAIL rst_obi_addr got %h want 0", obi_addr); end
    tests++; if (block !== '0) begin fails++; $display("FAIL rst_block got nonzero want 0"); end
    tests++; if ({block_valid, block_last} !== 2'b00) begin fails++; $display("FAIL rst_blk_flags got %b want 00", {block_valid, block_last}); end
    tests++; if ({busy, err} !== 2'b00) begin fails++; $display("FAIL rst_busy_err got %b want 00", {busy, err}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_block(input string name);
    int g0, b0, d0, a0;
    logic [511:0] exp;
    g0 = gnt_cnt; b0 = blk_q.size(); d0 = done_cnt; a0 = addr_q.size();
    for (int i = 0; i < 16; i++) exp[511-32*i -: 32] = mem(32'h1000_0000 + 32'(4*i));
    start_job(32'h1000_0000, 32'd16);
    wait_idle(name);
    tests++; if (gnt_cnt - g0 != 16) begin fails++; $display("FAIL %s_reads got %0d want 16", name, gnt_cnt - g0); end
    tests++; if (addr_q.size() < a0 + 16 || addr_q[a0] !== 32'h1000_0000 || addr_q[a0+15] !== 32'h1000_003C) begin
      fails++; $display("FAIL %s_addrs first/last wrong, got %0d reads want 0x10000000..0x1000003C", name, addr_q.size() - a0);
    end
    tests++; if (blk_q.size() - b0 != 1) begin fails++; $display("FAIL %s_blocks got %0d want 1", name, blk_q.size() - b0); end
    if (blk_q.size() > b0) begin
      tests++; if (blk_q[b0][511:480] !== 32'hC3A5_0000) begin fails++; $display("FAIL %s_word0 got %h want c3a50000", name, blk_q[b0][511:480]); end
      tests++; if (blk_q[b0][31:0] !== 32'hC399_003C) begin fails++; $display("FAIL %s_word15 got %h want c399003c", name, blk_q[b0][31:0]); end
      tests++; if (blk_q[b0] !== exp) begin fails++; $display("FAIL %s_block got %h want %h", name, blk_q[b0], exp); end
      tests++; if (last_q[b0] !== 1'b1) begin fails++; $display("FAIL %s_last got %b want 1", name, last_q[b0]); end
    end
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL %s_done got %0d want 1", name, done_cnt - d0); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL %s_err got %b want 0", name, err); end
    tests++; if (regs[3] !== 32'h1 || regs[2] !== 32'h0) begin fails++; $display("FAIL %s_regs got st=%h start=%h want 1/0", name, regs[3], regs[2]); end
  endtask

  task automatic test_back_to_back();
    int g0, b0, d0, v0, a0;
    g0 = gnt_cnt; b0 = blk_q.size(); d0 = done_cnt; v0 = viol; a0 = addr_q.size();
    rdy_delay = 20;
    start_job(32'h1000_0102, 32'd48);
    wait_idle("t2");
    rdy_delay = 0;
    tests++; if (gnt_cnt - g0 != 48) begin fails++; $display("FAIL t2_reads got %0d want 48", gnt_cnt - g0); end
    tests++; if (addr_q.size() <= a0 || addr_q[a0] !== 32'h1000_0100) begin fails++; $display("FAIL t2_align first addr wrong, want 10000100"); end
    tests++; if (blk_q.size() - b0 != 3) begin fails++; $display("FAIL t2_blocks got %0d want 3", blk_q.size() - b0); end
    if (blk_q.size() - b0 == 3) begin
      tests++; if ({last_q[b0], last_q[b0+1], last_q[b0+2]} !== 3'b001) begin
        fails++; $display("FAIL t2_last got %b want 001", {last_q[b0], last_q[b0+1], last_q[b0+2]});
      end
      tests++; if (blk_q[b0+2][511:480] !== 32'hC225_0180) begin fails++; $display("FAIL t2_blk3_word0 got %h want c2250180", blk_q[b0+2][511:480]); end
    end
    tests++; if (viol - v0 != 0) begin fails++; $display("FAIL t2_overlap got %0d req cycles during hand-off want 0", viol - v0); end
    tests++; if (done_cnt - d0 != 1 || err !== 1'b0) begin fails++; $display("FAIL t2_done got done=%0d err=%b want 1/0", done_cnt - d0, err); end
  endtask

  task automatic test_zero_len();
    int g0, b0, d0;
    g0 = gnt_cnt; b0 = blk_q.size(); d0 = done_cnt;
    start_job(32'h1000_0000, 32'd0);
    wait_idle("t3");
    tests++; if (gnt_cnt - g0 != 0) begin fails++; $display("FAIL t3_reads got %0d want 0", gnt_cnt - g0); end
    tests++; if (blk_q.size() - b0 != 0) begin fails++; $display("FAIL t3_blocks got %0d want 0", blk_q.size() - b0); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL t3_err got %b want 0", err); end
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL t3_done got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_bad_len();
    int g0, d0;
    g0 = gnt_cnt; d0 = done_cnt;
    start_job(32'h1000_0000, 32'd20);
    wait_idle("t4");
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL t4_err got %b want 1", err); end
    tests++; if (gnt_cnt - g0 != 0) begin fails++; $display("FAIL t4_reads got %0d want 0", gnt_cnt - g0); end
    tests++; if (done_cnt - d0 != 1 || regs[3] !== 32'h1) begin fails++; $display("FAIL t4_done got %0d st=%h want 1/1", done_cnt - d0, regs[3]); end
    test_single_block("t4_clear");
  endtask

  task automatic test_obi_err();
    int g0, b0, d0;
    g0 = gnt_cnt; b0 = blk_q.size(); d0 = done_cnt;
    err_at = gnt_cnt + 4;
    start_job(32'h1000_0200, 32'd16);
    wait_idle("t5");
    err_at = -1;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL t5_err got %b want 1", err); end
    tests++; if (gnt_cnt - g0 != 5) begin fails++; $display("FAIL t5_reads got %0d want 5", gnt_cnt - g0); end
    tests++; if (blk_q.size() - b0 != 0) begin fails++; $display("FAIL t5_blocks got %0d want 0", blk_q.size() - b0); end
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL t5_done got %0d want 1", done_cnt - d0); end
    tests++; if (done_cyc - err_cyc > 2 || done_cyc <= err_cyc) begin fails++; $display("FAIL t5_latency got %0d cycles want <=2", done_cyc - err_cyc); end
  endtask

  task automatic test_reset_mid_job();
    int r0, b0;
    bit reached;
    r0 = rsp_cnt; b0 = blk_q.size(); reached = 0;
    start_job(32'h1000_0000, 32'd48);
    for (int i = 0; i < 200 && !reached; i++) begin
      if (rsp_cnt - r0 >= 8) reached = 1;
      else @(negedge clk);
    end
    tests++; if (!reached) begin fails++; $display("FAIL t6_reach got %0d responses want 8", rsp_cnt - r0); end
    rst_n = 1'b0;
    #1;
    tests++; if ({busy, obi_req, block_valid, err} !== 4'b0000) begin
      fails++; $display("FAIL t6_rst_ctrl got busy/req/valid/err=%b want 0000", {busy, obi_req, block_valid, err});
    end
    tests++; if (acc_addr !== RB || obi_addr !== 32'h0) begin fails++; $display("FAIL t6_rst_addr got %h/%h want %h/0", acc_addr, obi_addr, RB); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (blk_q.size() - b0 != 0 || busy !== 1'b0) begin fails++; $display("FAIL t6_idle got blocks=%0d busy=%b want 0/0", blk_q.size() - b0, busy); end
    test_single_block("t6_rerun");
  endtask

  initial begin
    test_reset();
    test_single_block("t1");
    test_back_to_back();
    test_zero_len();
    test_bad_len();
    test_obi_err();
    test_reset_mid_job();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not end, want finish");
    $fatal(1);
  end
endmodule
